// File: rtl/adder_round_pkg.sv
// Shared types and elaboration helpers for the streaming multi-input adder
// with run-time rounding mode and output saturation.
package adder_round_pkg;

    typedef enum logic [1:0] {
        RND_EVEN  = 2'd0,
        RND_TRUNC = 2'd1,
        RND_AWAY  = 2'd2
    } round_mode_t;

    localparam int SAT_CNT_W = 16;

    function automatic int sum_width(input int num, input int win);
        return win + $clog2(num);
    endfunction

    // Operands left at a given tree level; an odd leftover rides up unpaired.
    function automatic int node_count(input int num, input int lvl);
        int c;
        c = num;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/multi_input_adder_round_stream_round_sat_stage.sv
// Registered round/saturate stage: drops DROP_LSB bits using the beat's own
// rounding mode, then clips to WIDTH_OUT and flags beats that were clipped.
module round_sat_stage
    import adder_round_pkg::*;
#(
    parameter int WIDTH_IN  = 10,
    parameter int WIDTH_OUT = 8,
    parameter int DROP_LSB  = 2,
    parameter int IS_SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 in_valid,
    input  logic [WIDTH_IN-1:0]  in_sum,
    input  round_mode_t          in_mode,
    output logic                 out_valid,
    output logic [WIDTH_OUT-1:0] dout,
    output logic                 dout_sat
);

    localparam int W  = WIDTH_IN;
    localparam int CW = (W + 1 > WIDTH_OUT + 1) ? W + 1 : WIDTH_OUT + 1;
    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] MAX_V = (IS_SIGNED != 0) ? (ONE <<< (WIDTH_OUT - 1)) - ONE
                                                              : (ONE <<< WIDTH_OUT) - ONE;
    localparam logic signed [CW-1:0] MIN_V = (IS_SIGNED != 0) ? -(ONE <<< (WIDTH_OUT - 1)) : '0;

    logic signed [W:0]    s_ext;
    logic signed [W:0]    rounded;
    logic signed [CW-1:0] r_w;
    logic [WIDTH_OUT-1:0] dout_next;
    logic                 sat_next;
    logic                 out_valid_reg;
    logic [WIDTH_OUT-1:0] dout_reg;
    logic                 sat_reg;

    // One extra bit so the rounding carry out of the top can never be lost.
    assign s_ext = (IS_SIGNED != 0) ? {in_sum[W-1], in_sum} : {1'b0, in_sum};

    if (DROP_LSB == 0) begin : g_bypass
        logic unused_mode;
        assign unused_mode = ^in_mode;
        assign rounded     = s_ext;
    end else begin : g_round
        localparam int DM1 = DROP_LSB - 1;
        localparam logic [W:0] REST_MASK = (W + 1)'((1 << DM1) - 1);
        logic signed [W:0] q;
        logic half;
        logic rest;
        logic inc;
        always_comb begin
            q    = s_ext >>> DROP_LSB;
            half = s_ext[DM1];
            rest = |(s_ext & REST_MASK);
            // q is the floor, so a negative exact tie is already "away" from zero.
            case (in_mode)
                RND_TRUNC: inc = 1'b0;
                RND_AWAY:  inc = half & (~s_ext[W] | rest);
                default:   inc = half & (rest | q[0]);
            endcase
            rounded = q + {{W{1'b0}}, inc};
        end
    end

    always_comb begin
        r_w       = CW'(rounded);
        sat_next  = 1'b0;
        dout_next = r_w[WIDTH_OUT-1:0];
        if (r_w > MAX_V) begin
            dout_next = MAX_V[WIDTH_OUT-1:0];
            sat_next  = 1'b1;
        end else if (r_w < MIN_V) begin
            dout_next = MIN_V[WIDTH_OUT-1:0];
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            sat_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                dout_reg <= dout_next;
                sat_reg  <= sat_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign dout      = dout_reg;
    assign dout_sat  = sat_reg;

endmodule

// File: rtl/multi_input_adder_round_stream.sv
// Pipelined N-input adder tree with valid/ready stream, per-beat rounding mode
// and saturation. Optional saturation event counter: MIA_ROUND_SAT_COUNT_EN.
module multi_input_adder_round_stream
    import adder_round_pkg::*;
#(
    parameter int NUM_INPUT = 4,
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 8,
    parameter int DROP_LSB  = 2,
    parameter int IS_SIGNED = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic                               din_valid,
    output logic                               din_ready,
    input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0] din,
    input  logic [1:0]                         rnd_mode,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    output logic [WIDTH_OUT-1:0]               dout,
    output logic                               dout_sat
`ifdef MIA_ROUND_SAT_COUNT_EN
    ,
    input  logic                               sat_clr,
    output logic [SAT_CNT_W-1:0]               sat_count
`endif
);

    localparam int WIDTH_SUM = sum_width(NUM_INPUT, WIDTH_IN);
    localparam int LEVELS    = $clog2(NUM_INPUT);
    localparam int EXT       = WIDTH_SUM - WIDTH_IN;

    if (NUM_INPUT < 2) begin : g_chk_num
        $error("NUM_INPUT must be at least 2");
    end
    if (WIDTH_IN <= 0) begin : g_chk_win
        $error("WIDTH_IN must be positive");
    end
    if (WIDTH_OUT <= 0) begin : g_chk_wout
        $error("WIDTH_OUT must be positive");
    end
    if (DROP_LSB >= WIDTH_SUM) begin : g_chk_drop
        $error("DROP_LSB must be below the sum width");
    end

    // Whole pipeline moves together; a held output stalls everything upstream.
    logic adv;
    assign adv       = ena & (~dout_valid | dout_ready);
    assign din_ready = adv;

    genvar gl, gi;
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
        localparam int CNT = node_count(NUM_INPUT, gl);
        logic [WIDTH_SUM-1:0] node [CNT];
        logic                 vld;
        round_mode_t          mode;

        if (gl == 0) begin : g_in
            for (gi = 0; gi < CNT; gi++) begin : g_ext
                if (IS_SIGNED != 0) begin : g_sx
                    assign node[gi] = {{EXT{din[gi][WIDTH_IN-1]}}, din[gi]};
                end else begin : g_zx
                    assign node[gi] = {{EXT{1'b0}}, din[gi]};
                end
            end
            assign vld  = din_valid;
            assign mode = (rnd_mode == 2'b11) ? RND_EVEN : round_mode_t'(rnd_mode);
        end else begin : g_reg
            localparam int PCNT = node_count(NUM_INPUT, gl - 1);
            for (gi = 0; gi < CNT; gi++) begin : g_node
                logic [WIDTH_SUM-1:0] node_next;
                if (2 * gi + 1 < PCNT) begin : g_pair
                    assign node_next = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
                end else begin : g_pass
                    assign node_next = g_lvl[gl-1].node[2*gi];
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        node[gi] <= '0;
                    end else if (adv && g_lvl[gl-1].vld) begin
                        node[gi] <= node_next;
                    end
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld  <= 1'b0;
                    mode <= RND_EVEN;
                end else if (adv) begin
                    vld <= g_lvl[gl-1].vld;
                    if (g_lvl[gl-1].vld) begin
                        mode <= g_lvl[gl-1].mode;
                    end
                end
            end
        end
    end

    round_sat_stage #(
        .WIDTH_IN  (WIDTH_SUM),
        .WIDTH_OUT (WIDTH_OUT),
        .DROP_LSB  (DROP_LSB),
        .IS_SIGNED (IS_SIGNED)
    ) u_round_sat (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .in_valid  (g_lvl[LEVELS].vld),
        .in_sum    (g_lvl[LEVELS].node[0]),
        .in_mode   (g_lvl[LEVELS].mode),
        .out_valid (dout_valid),
        .dout      (dout),
        .dout_sat  (dout_sat)
    );

`ifdef MIA_ROUND_SAT_COUNT_EN
    logic [SAT_CNT_W-1:0] sat_count_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_reg <= '0;
        end else if (sat_clr) begin
            sat_count_reg <= '0;
        end else if (ena && dout_valid && dout_ready && dout_sat && !(&sat_count_reg)) begin
            sat_count_reg <= sat_count_reg + SAT_CNT_W'(1);
        end
    end
    assign sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_multi_input_adder_round_stream.sv
// Directed bench for multi_input_adder_round_stream: four instances cover the
// default rounding config, signed/unsigned saturation and an odd operand count.
module tb_multi_input_adder_round_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // d0: defaults; d1: DROP_LSB=0 signed; d2: DROP_LSB=0 unsigned; d3: N=5, WOUT=11
    logic ena0, dv0, dr0, ov0, ordy0, sat0;
    logic ena1, dv1, dr1, ov1, ordy1, sat1;
    logic ena2, dv2, dr2, ov2, ordy2, sat2;
    logic ena3, dv3, dr3, ov3, ordy3, sat3;
    logic [3:0][7:0] din0, din1, din2;
    logic [4:0][7:0] din3;
    logic [1:0] mode0, mode1, mode2, mode3;
    logic [7:0] dout0, dout1, dout2;
    logic [10:0] dout3;
`ifdef MIA_ROUND_SAT_COUNT_EN
    logic sat_clr;
    logic [15:0] sc0, sc1, sc2, sc3;
`endif

    multi_input_adder_round_stream dut0 (
        .clk(clk), .rst(rst), .ena(ena0), .din_valid(dv0), .din_ready(dr0), .din(din0),
        .rnd_mode(mode0), .dout_valid(ov0), .dout_ready(ordy0), .dout(dout0), .dout_sat(sat0)
`ifdef MIA_ROUND_SAT_COUNT_EN
        , .sat_clr(sat_clr), .sat_count(sc0)
`endif
    );

    multi_input_adder_round_stream #(.DROP_LSB(0)) dut1 (
        .clk(clk), .rst(rst), .ena(ena1), .din_valid(dv1), .din_ready(dr1), .din(din1),
        .rnd_mode(mode1), .dout_valid(ov1), .dout_ready(ordy1), .dout(dout1), .dout_sat(sat1)
`ifdef MIA_ROUND_SAT_COUNT_EN
        , .sat_clr(sat_clr), .sat_count(sc1)
`endif
    );

    multi_input_adder_round_stream #(.DROP_LSB(0), .IS_SIGNED(0)) dut2 (
        .clk(clk), .rst(rst), .ena(ena2), .din_valid(dv2), .din_ready(dr2), .din(din2),
        .rnd_mode(mode2), .dout_valid(ov2), .dout_ready(ordy2), .dout(dout2), .dout_sat(sat2)
`ifdef MIA_ROUND_SAT_COUNT_EN
        , .sat_clr(sat_clr), .sat_count(sc2)
`endif
    );

    multi_input_adder_round_stream #(.NUM_INPUT(5), .DROP_LSB(0), .WIDTH_OUT(11)) dut3 (
        .clk(clk), .rst(rst), .ena(ena3), .din_valid(dv3), .din_ready(dr3), .din(din3),
        .rnd_mode(mode3), .dout_valid(ov3), .dout_ready(ordy3), .dout(dout3), .dout_sat(sat3)
`ifdef MIA_ROUND_SAT_COUNT_EN
        , .sat_clr(sat_clr), .sat_count(sc3)
`endif
    );

    // Drives one isolated beat into the selected instance and waits for its result.
    task automatic beat(input int sel, input logic [7:0] a, b, c, d, e, input logic [1:0] m,
                        output logic [10:0] res, output logic s, output int lat);
        bit   done;
        logic v;
        @(negedge clk);
        case (sel)
            0: begin din0 = {d, c, b, a}; mode0 = m; dv0 = 1'b1; end
            1: begin din1 = {d, c, b, a}; mode1 = m; dv1 = 1'b1; end
            2: begin din2 = {d, c, b, a}; mode2 = m; dv2 = 1'b1; end
            default: begin din3 = {e, d, c, b, a}; mode3 = m; dv3 = 1'b1; end
        endcase
        lat  = -1;
        res  = '0;
        s    = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0; dv3 = 1'b0; end
            case (sel)
                0: begin v = ov0; res = {3'b000, dout0}; s = sat0; end
                1: begin v = ov1; res = {3'b000, dout1}; s = sat1; end
                2: begin v = ov2; res = {3'b000, dout2}; s = sat2; end
                default: begin v = ov3; res = dout3; s = sat3; end
            endcase
            if (v) begin
                done = 1'b1;
                lat  = k;
            end
        end
        $display("beat dut=%0d ops=%h,%h,%h,%h,%h mode=%0d dout=%h sat=%0b lat=%0d",
                 sel, a, b, c, d, e, m, res, s, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ov0); end
        checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout0); end
        checks++; if (sat0 !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat0); end
        checks++; if (ov3 !== 1'b0 || dout3 !== 11'h000) begin
            failures++; $display("FAIL reset_d3 valid=%b dout=%h exp 0/000", ov3, dout3);
        end
`ifdef MIA_ROUND_SAT_COUNT_EN
        checks++; if (sc0 !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", sc0); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (dr0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dr0); end
        $display("reset released valid=%b dout=%h ready=%b", ov0, dout0, dr0);
    endtask

    task automatic test_modes;
        logic [7:0]  ops [12][4];
        logic [1:0]  md  [12];
        logic [7:0]  ex  [12];
        logic [10:0] res;
        logic        s;
        int          lat;
        ops = '{'{8'd1, 8'd1, 8'd1, 8'd3}, '{8'd1, 8'd1, 8'd1, 8'd3}, '{8'd1, 8'd1, 8'd1, 8'd3},
                '{8'd1, 8'd1, 8'd1, 8'd3}, '{8'd2, 8'd2, 8'd3, 8'd3}, '{8'd2, 8'd2, 8'd3, 8'd3},
                '{8'd2, 8'd2, 8'd3, 8'd3}, '{8'd1, 8'd1, 8'd1, 8'd4}, '{8'd1, 8'd1, 8'd1, 8'd2},
                '{8'hFF, 8'hFF, 8'hFF, 8'hF9}, '{8'hFF, 8'hFF, 8'hFF, 8'hF9}, '{8'hFF, 8'hFF, 8'hFF, 8'hF9}};
        md  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2};
        ex  = '{8'd2, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd2, 8'd1, 8'hFE, 8'hFD, 8'hFD};
        for (int i = 0; i < 12; i++) begin
            beat(0, ops[i][0], ops[i][1], ops[i][2], ops[i][3], 8'd0, md[i], res, s, lat);
            checks++; if (res[7:0] !== ex[i]) begin
                failures++; $display("FAIL mode_value[%0d] got=%h exp=%h", i, res[7:0], ex[i]);
            end
            checks++; if (s !== 1'b0) begin failures++; $display("FAIL mode_sat[%0d] got=%b exp=0", i, s); end
            checks++; if (lat != 3) begin failures++; $display("FAIL mode_latency[%0d] got=%0d exp=3", i, lat); end
        end
    endtask

    task automatic test_neg_away;
        logic [10:0] res;
        logic        s;
        int          lat;
        // -9/4 = -2.25: nearest is -2 under both RNE and away
        beat(0, 8'hFF, 8'hFF, 8'hFF, 8'hFA, 8'd0, 2'd2, res, s, lat);
        checks++; if (res[7:0] !== 8'hFE) begin failures++; $display("FAIL neg_away got=%h exp=FE", res[7:0]); end
        beat(0, 8'hFF, 8'hFF, 8'hFF, 8'hFA, 8'd0, 2'd1, res, s, lat);
        checks++; if (res[7:0] !== 8'hFD) begin failures++; $display("FAIL neg_trunc got=%h exp=FD", res[7:0]); end
    endtask

    task automatic test_saturation;
        int          sel [10];
        logic [7:0]  ops [10][4];
        logic [7:0]  ex  [10];
        logic        exs [10];
        logic [10:0] res;
        logic        s;
        int          lat;
        sel = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
        ops = '{'{8'd100, 8'd100, 8'd100, 8'd100}, '{8'h80, 8'h80, 8'h80, 8'h80},
                '{8'd127, 8'd0, 8'd0, 8'd0},       '{8'd32, 8'd32, 8'd32, 8'd32},
                '{8'hE0, 8'hE0, 8'hE0, 8'hE0},     '{8'hDF, 8'hE0, 8'hE0, 8'hE0},
                '{8'd10, 8'd20, 8'd30, 8'd40},     '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
                '{8'd50, 8'd60, 8'd70, 8'd75},     '{8'd64, 8'd64, 8'd64, 8'd64}};
        ex  = '{8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'd100, 8'hFF, 8'hFF, 8'hFF};
        exs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            beat(sel[i], ops[i][0], ops[i][1], ops[i][2], ops[i][3], 8'd0, 2'd0, res, s, lat);
            checks++; if (res[7:0] !== ex[i]) begin
                failures++; $display("FAIL sat_value[%0d] got=%h exp=%h", i, res[7:0], ex[i]);
            end
            checks++; if (s !== exs[i]) begin
                failures++; $display("FAIL sat_flag[%0d] got=%b exp=%b", i, s, exs[i]);
            end
            checks++; if (lat != 3) begin failures++; $display("FAIL sat_latency[%0d] got=%0d exp=3", i, lat); end
        end
`ifdef MIA_ROUND_SAT_COUNT_EN
        checks++; if (sc1 !== 16'd4) begin failures++; $display("FAIL sat_count1 got=%0d exp=4", sc1); end
        checks++; if (sc2 !== 16'd2) begin failures++; $display("FAIL sat_count2 got=%0d exp=2", sc2); end
`endif
    endtask

    task automatic test_backpressure;
        int         sent, rcv, cyc;
        bit         held;
        logic [7:0] held_val;
        sent = 0; rcv = 0; cyc = 0; held = 1'b0; held_val = '0;
        mode0 = 2'd0;
        while (rcv < 8 && cyc < 100) begin
            @(negedge clk);
            ordy0 = (cyc % 2 == 0);
            dv0   = (sent < 8);
            din0  = {4{8'(sent + 1)}};
            #1;
            if (held) begin
                checks++; if (ov0 !== 1'b1 || dout0 !== held_val) begin
                    failures++; $display("FAIL bp_hold valid=%b dout=%h exp 1/%h", ov0, dout0, held_val);
                end
            end
            if (ov0 && !ordy0) begin
                checks++; if (dr0 !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", dr0); end
                held = 1'b1; held_val = dout0;
            end else begin
                held = 1'b0;
            end
            if (ov0 && ordy0) begin
                checks++; if (dout0 !== 8'(rcv + 1)) begin
                    failures++; $display("FAIL bp_order got=%0d exp=%0d", dout0, rcv + 1);
                end
                $display("bp out cyc=%0d dout=%0d", cyc, dout0);
                rcv++;
            end
            if (dv0 && dr0) sent++;
            cyc++;
        end
        checks++; if (rcv != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rcv); end
        @(negedge clk);
        dv0 = 1'b0; ordy0 = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", ov0); end
    endtask

    task automatic test_odd_count;
        logic [10:0] res;
        logic        s;
        int          lat;
        beat(3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 2'd0, res, s, lat);
        checks++; if (res !== 11'd15) begin failures++; $display("FAIL odd_value got=%0d exp=15", res); end
        checks++; if (lat != 4) begin failures++; $display("FAIL odd_latency got=%0d exp=4", lat); end
        beat(3, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 2'd0, res, s, lat);
        checks++; if (res !== 11'h7F1) begin failures++; $display("FAIL odd_neg got=%h exp=7F1", res); end
    endtask

    task automatic test_enable;
        bit done;
        int lat;
        @(negedge clk);
        din3 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; dv3 = 1'b1;
        done = 1'b0; lat = -1;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (k == 1) dv3 = 1'b0;
            if (k == 2) ena3 = 1'b0;
            if (k == 5) ena3 = 1'b1;
            if (ov3) begin done = 1'b1; lat = k; end
        end
        $display("ena stall dout=%0d lat=%0d", dout3, lat);
        checks++; if (lat != 7) begin failures++; $display("FAIL ena_latency got=%0d exp=7", lat); end
        checks++; if (dout3 !== 11'd15) begin failures++; $display("FAIL ena_value got=%0d exp=15", dout3); end
        ena3 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ov3 !== 1'b1 || dout3 !== 11'd15 || dr3 !== 1'b0) begin
            failures++; $display("FAIL ena_hold valid=%b dout=%0d ready=%b exp 1/15/0", ov3, dout3, dr3);
        end
        ena3 = 1'b1;
        @(negedge clk);
        checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL ena_drain got=%b exp=0", ov3); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] res;
        logic        s;
        int          lat;
        bit          seen;
        @(negedge clk);
        din0 = {4{8'd20}}; mode0 = 2'd0; dv0 = 1'b1;
        @(negedge clk);
        din0 = {4{8'd24}};
        @(negedge clk);
        dv0 = 1'b0;
        @(negedge clk);
        checks++; if (ov0 !== 1'b1 || dout0 !== 8'd20) begin
            failures++; $display("FAIL rstmid_pre valid=%b dout=%0d exp 1/20", ov0, dout0);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0 || dout0 !== 8'd0) begin
            failures++; $display("FAIL rstmid_async valid=%b dout=%0d exp 0/0", ov0, dout0);
        end
`ifdef MIA_ROUND_SAT_COUNT_EN
        checks++; if (sc1 !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", sc1); end
`endif
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ov0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rstmid_flush got=1 exp=0"); end
        beat(0, 8'd1, 8'd1, 8'd1, 8'd3, 8'd0, 2'd1, res, s, lat);
        checks++; if (res[7:0] !== 8'd1 || lat != 3) begin
            failures++; $display("FAIL rstmid_after dout=%0d lat=%0d exp 1/3", res[7:0], lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        {ena0, ena1, ena2, ena3}     = 4'hF;
        {ordy0, ordy1, ordy2, ordy3} = 4'hF;
        {dv0, dv1, dv2, dv3}         = 4'h0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        mode0 = 2'd0; mode1 = 2'd0; mode2 = 2'd0; mode3 = 2'd0;
`ifdef MIA_ROUND_SAT_COUNT_EN
        sat_clr = 1'b0;
`endif
        test_reset;
        test_modes;
        test_neg_away;
        test_saturation;
        test_backpressure;
        test_odd_count;
        test_enable;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_input_adder_round_stream.md
Name: multi_input_adder_round_stream

Overview:
- Pipelined N-input adder tree followed by a registered round/saturate stage.
- Adds a valid/ready stream handshake, run-time rounding-mode selection, an explicit LSB-drop count and a saturation flag.
- Successor to the team's fixed-mode multi-input adder-with-rounding; used in filter and beamforming datapaths where downstream may stall.

Parameters:
- NUM_INPUT, 4, number of summed operands (>=2)
- WIDTH_IN, 8, bit width of each operand (>0)
- WIDTH_OUT, 8, output width after rounding/saturation (>0)
- DROP_LSB, 2, LSBs discarded by rounding (0..WIDTH_SUM-1); WIDTH_SUM = WIDTH_IN + $clog2(NUM_INPUT)
- IS_SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  global clock enable; 0 freezes all state
- din_valid  in  1  operand vector valid
- din_ready  out  1  block can accept operands this cycle
- din  in  NUM_INPUT x WIDTH_IN  operand array
- rnd_mode  in  2  rounding mode, sampled with din
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result
- dout  out  WIDTH_OUT  rounded, saturated sum
- dout_sat  out  1  dout was clipped

Behaviour:
- Reset: all pipeline valid bits 0; dout = 0, dout_valid = 0, dout_sat = 0. Data registers clear to 0.
- Pipeline advance: adv = ena & (~dout_valid | dout_ready).
  - din_ready = adv.
  - A beat is accepted when din_valid & din_ready.
  - When adv = 0, every register, valid bit and mode holds; there are no bubbles and no drops.
- Latency: LAT = $clog2(NUM_INPUT) + 1 advancing cycles from acceptance to dout_valid.
  - One register per adder-tree level plus the round stage.
  - Full throughput is one beat per cycle while adv = 1.
- Adder tree:
  - Operands are sign- or zero-extended to WIDTH_SUM per IS_SIGNED.
  - Pairwise add per level; an odd leftover operand passes through registered.
  - Full width, so the tree never overflows.
  - rnd_mode and the valid bit travel alongside the data.
- Round stage, on sum S with drop D = DROP_LSB:
  - 00 = round-half-to-even.
  - 01 = truncate (floor; for signed, toward minus infinity).
  - 10 = round-half-away-from-zero (unsigned: half-up).
  - 11 = treated as 00.
  - D = 0 bypasses rounding.
  - The rounding increment is computed at WIDTH_SUM+1 bits so that +1 carry is never lost.
- Saturation:
  - Signed results clip to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]; unsigned to [0, 2^WIDTH_OUT-1].
  - dout_sat = 1 on exactly the beats where clipping occurred, and is valid with dout_valid.
- Output hold: while dout_valid & ~dout_ready, dout and dout_sat are stable.
- ena = 0 with dout_valid = 1: the output holds and dout_valid stays 1.
- Reset mid-operation: all in-flight beats are discarded; dout_valid drops asynchronously.
- Elaboration $error when any of the following holds:
  - NUM_INPUT < 2
  - WIDTH_IN <= 0
  - WIDTH_OUT <= 0
  - DROP_LSB >= WIDTH_SUM

Optional Feature:
- Macro MIA_ROUND_SAT_COUNT_EN.
- Defined:
  - Adds output sat_count (16 bits) and input sat_clr (1).
  - sat_count increments by 1 on each output handshake (dout_valid & dout_ready) with dout_sat = 1.
  - It saturates at 0xFFFF and does not wrap.
  - sat_clr is a synchronous clear and wins over a same-cycle increment.
  - sat_count resets to 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package adder_round_pkg:
  - round_mode_t enum: RND_EVEN = 0, RND_TRUNC = 1, RND_AWAY = 2.
  - Function sum_width(num, win).
  - Constant SAT_CNT_W = 16.
- One sub-module, round_sat_stage.
  - Parameters WIDTH_IN = WIDTH_SUM, WIDTH_OUT, DROP_LSB, IS_SIGNED.
  - Registered, stall-aware; takes adv, produces dout and dout_sat.
- The tree stays in the top level as a generate loop.

Test Plan (defaults unless stated):
- Modes, positive:
  - {1,1,1,3} (S=6, 1.5) -> RNE 2, TRUNC 1, AWAY 2.
  - {2,2,3,3} (S=10, 2.5) -> RNE 2, TRUNC 2, AWAY 3.
  - All beats arrive 3 cycles after acceptance.
- Negative ties: {-1,-1,-1,-7} (S=-10, -2.5) -> RNE -2, TRUNC -3, AWAY -3; dout_sat = 0.
- Saturation, DROP_LSB=0:
  - {100,100,100,100} -> 127, dout_sat = 1.
  - {-128,-128,-128,-128} -> -128, dout_sat = 1.
  - IS_SIGNED=0 with {255,255,255,255} -> 255, dout_sat = 1.
- Backpressure:
  - Stream 8 beats 1..8 (all four operands = k) with dout_ready toggling 1010...
  - Required: outputs k in order, none lost or duplicated, dout stable while stalled, din_ready low whenever the output is held.
- Odd count and enable, NUM_INPUT=5, DROP_LSB=0, WIDTH_OUT=11:
  - {1,2,3,4,5} -> 15 after 4 cycles.
  - ena = 0 for 3 cycles mid-flight delays the result by exactly 3 cycles.
- Reset mid-stream: rst asserted with 2 beats in flight -> dout_valid = 0 immediately and stays 0; the first beat after release appears with correct value and latency. With MIA_ROUND_SAT_COUNT_EN, sat_count returns to 0.
